// File: rtl/ex_test_sequencer.sv
// Test-vector sequencer for the execute-stage harness: holds a writable
// vector table, issues vectors over a req/valid handshake, checks results
// with a per-vector timeout and keeps saturating pass/fail counters.
module ex_test_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned OP_W    = 7,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [1:0]               mode_i,
  input  logic [$clog2(DEPTH)-1:0] sel_i,
  input  logic                     tbl_we_i,
  input  logic [$clog2(DEPTH)-1:0] tbl_addr_i,
  input  logic [OP_W-1:0]          tbl_op_i,
  input  logic [WIDTH-1:0]         tbl_a_i,
  input  logic [WIDTH-1:0]         tbl_b_i,
  input  logic [WIDTH-1:0]         tbl_exp_i,
  output logic                     dut_req_o,
  output logic [OP_W-1:0]          dut_op_o,
  output logic [WIDTH-1:0]         dut_a_o,
  output logic [WIDTH-1:0]         dut_b_o,
  input  logic                     dut_valid_i,
  input  logic [WIDTH-1:0]         dut_result_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [$clog2(DEPTH)-1:0] last_idx_o,
  output logic [WIDTH-1:0]         last_result_o,
  output logic [CNT_W-1:0]         pass_cnt_o,
  output logic [CNT_W-1:0]         fail_cnt_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TO_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Vector table storage
  logic [OP_W-1:0]  tbl_op_q  [DEPTH];
  logic [WIDTH-1:0] tbl_a_q   [DEPTH];
  logic [WIDTH-1:0] tbl_b_q   [DEPTH];
  logic [WIDTH-1:0] tbl_exp_q [DEPTH];

  logic             start_prev_q;
  logic             go;
  logic             wr_en;
  logic             finish;
  logic             mode_runall;
  logic             mode_loop;

  logic [1:0]       mode_q, mode_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic             match_q, match_d;

  logic             req_d, busy_d, done_d, pass_d, timeout_d;
  logic [OP_W-1:0]  op_d;
  logic [WIDTH-1:0] a_d, b_d, last_result_d;
  logic [IDX_W-1:0] last_idx_d;
  logic [CNT_W-1:0] pass_cnt_d, fail_cnt_d;

  assign go          = start_i & ~start_prev_q;
  assign wr_en       = tbl_we_i & ~busy_o;
  assign mode_runall = (mode_q == 2'd1);
  assign mode_loop   = (mode_q == 2'd2);

  // Table write port; writes are only taken while no run is in progress
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        tbl_op_q[i]  <= '0;
        tbl_a_q[i]   <= '0;
        tbl_b_q[i]   <= '0;
        tbl_exp_q[i] <= '0;
      end
    end else if (wr_en) begin
      tbl_op_q[tbl_addr_i]  <= tbl_op_i;
      tbl_a_q[tbl_addr_i]   <= tbl_a_i;
      tbl_b_q[tbl_addr_i]   <= tbl_b_i;
      tbl_exp_q[tbl_addr_i] <= tbl_exp_i;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, including the end-of-run decision in CHECK
  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dut_valid_i || (tcnt_q == '0)) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (mode_runall)    finish = (idx_q == IDX_W'(DEPTH - 1));
        else if (mode_loop) finish = stop_i;
        else                finish = 1'b1;
        state_d = finish ? ST_IDLE : ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the datapath and of every registered output
  always_comb begin
    idx_d         = idx_q;
    mode_d        = mode_q;
    tcnt_d        = tcnt_q;
    match_d       = match_q;
    op_d          = dut_op_o;
    a_d           = dut_a_o;
    b_d           = dut_b_o;
    busy_d        = busy_o;
    done_d        = 1'b0;
    pass_d        = pass_o;
    timeout_d     = timeout_o;
    last_idx_d    = last_idx_o;
    last_result_d = last_result_o;
    pass_cnt_d    = pass_cnt_o;
    fail_cnt_d    = fail_cnt_o;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          idx_d      = ((mode_i == 2'd1) || (mode_i == 2'd2)) ? '0 : sel_i;
          mode_d     = mode_i;
          timeout_d  = 1'b0;
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      ST_ISSUE: begin
        tcnt_d = TO_W'(TIMEOUT - 1);
      end
      ST_WAIT: begin
        if (dut_valid_i) begin
          last_result_d = dut_result_i;
          match_d       = (dut_result_i == tbl_exp_q[idx_q]);
        end else if (tcnt_q == '0) begin
          last_result_d = '0;
          match_d       = 1'b0;
          timeout_d     = 1'b1;
        end else begin
          tcnt_d = TO_W'(tcnt_q - 1'b1);
        end
      end
      ST_CHECK: begin
        pass_d     = match_q;
        last_idx_d = idx_q;
        if (match_q) begin
          if (pass_cnt_o != '1) pass_cnt_d = CNT_W'(pass_cnt_o + 1'b1);
        end else begin
          if (fail_cnt_o != '1) fail_cnt_d = CNT_W'(fail_cnt_o + 1'b1);
        end
        if (!finish) idx_d = IDX_W'(idx_q + 1'b1);
        done_d = finish;
        busy_d = ~finish;
      end
      default: ;
    endcase

    // Operands are loaded on entry to ISSUE; a same-cycle idle write is forwarded
    if ((state_d == ST_ISSUE) && (state_q != ST_ISSUE)) begin
      if (wr_en && (tbl_addr_i == idx_d)) begin
        op_d = tbl_op_i;
        a_d  = tbl_a_i;
        b_d  = tbl_b_i;
      end else begin
        op_d = tbl_op_q[idx_d];
        a_d  = tbl_a_q[idx_d];
        b_d  = tbl_b_q[idx_d];
      end
    end

    req_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
  end

  // Datapath and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_prev_q  <= 1'b0;
      idx_q         <= '0;
      mode_q        <= '0;
      tcnt_q        <= '0;
      match_q       <= 1'b0;
      dut_req_o     <= 1'b0;
      dut_op_o      <= '0;
      dut_a_o       <= '0;
      dut_b_o       <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      timeout_o     <= 1'b0;
      last_idx_o    <= '0;
      last_result_o <= '0;
      pass_cnt_o    <= '0;
      fail_cnt_o    <= '0;
    end else begin
      start_prev_q  <= start_i;
      idx_q         <= idx_d;
      mode_q        <= mode_d;
      tcnt_q        <= tcnt_d;
      match_q       <= match_d;
      dut_req_o     <= req_d;
      dut_op_o      <= op_d;
      dut_a_o       <= a_d;
      dut_b_o       <= b_d;
      busy_o        <= busy_d;
      done_o        <= done_d;
      pass_o        <= pass_d;
      timeout_o     <= timeout_d;
      last_idx_o    <= last_idx_d;
      last_result_o <= last_result_d;
      pass_cnt_o    <= pass_cnt_d;
      fail_cnt_o    <= fail_cnt_d;
    end
  end

endmodule

// File: tb/tb_ex_test_sequencer.sv
// Self-checking bench for ex_test_sequencer with a behavioural DUT responder
// and a table-level reference model of each run.
module tb_ex_test_sequencer;

  localparam int unsigned W     = 32;
  localparam int unsigned D     = 8;
  localparam int unsigned OP_W  = 7;
  localparam int unsigned TO    = 64;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = $clog2(D);

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic             stop_i = 1'b0;
  logic [1:0]       mode_i = '0;
  logic [IDX_W-1:0] sel_i = '0;
  logic             tbl_we_i = 1'b0;
  logic [IDX_W-1:0] tbl_addr_i = '0;
  logic [OP_W-1:0]  tbl_op_i = '0;
  logic [W-1:0]     tbl_a_i = '0;
  logic [W-1:0]     tbl_b_i = '0;
  logic [W-1:0]     tbl_exp_i = '0;
  logic             dut_req_o;
  logic [OP_W-1:0]  dut_op_o;
  logic [W-1:0]     dut_a_o;
  logic [W-1:0]     dut_b_o;
  logic             dut_valid_i = 1'b0;
  logic [W-1:0]     dut_result_i = '0;
  logic             busy_o, done_o, pass_o, timeout_o;
  logic [IDX_W-1:0] last_idx_o;
  logic [W-1:0]     last_result_o;
  logic [CNT_W-1:0] pass_cnt_o, fail_cnt_o;

  ex_test_sequencer #(
    .WIDTH(W), .DEPTH(D), .OP_W(OP_W), .TIMEOUT(TO), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .mode_i(mode_i), .sel_i(sel_i), .tbl_we_i(tbl_we_i), .tbl_addr_i(tbl_addr_i),
    .tbl_op_i(tbl_op_i), .tbl_a_i(tbl_a_i), .tbl_b_i(tbl_b_i), .tbl_exp_i(tbl_exp_i),
    .dut_req_o(dut_req_o), .dut_op_o(dut_op_o), .dut_a_o(dut_a_o), .dut_b_o(dut_b_o),
    .dut_valid_i(dut_valid_i), .dut_result_i(dut_result_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .last_idx_o(last_idx_o), .last_result_o(last_result_o),
    .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference copy of the vector table
  logic [OP_W-1:0] m_op  [D];
  logic [W-1:0]    m_a   [D];
  logic [W-1:0]    m_b   [D];
  logic [W-1:0]    m_exp [D];

  // Responder state: answers resp_lat cycles after the first WAIT cycle
  int resp_lat = 0;
  bit resp_en  = 1'b1;
  int req_age  = 0;

  function automatic logic [W-1:0] alu(input logic [OP_W-1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs are updated 1 time unit after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (dut_req_o) req_age++;
    else req_age = 0;
    dut_valid_i  = resp_en && dut_req_o && (req_age == 2 + resp_lat);
    dut_result_i = dut_valid_i ? alu(dut_op_o, dut_a_o, dut_b_o) : W'($urandom);
  endtask

  task automatic wr(input int idx, input logic [OP_W-1:0] op, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic [W-1:0] e);
    tbl_we_i = 1'b1; tbl_addr_i = IDX_W'(idx);
    tbl_op_i = op; tbl_a_i = a; tbl_b_i = b; tbl_exp_i = e;
    tick();
    tbl_we_i = 1'b0;
    m_op[idx] = op; m_a[idx] = a; m_b[idx] = b; m_exp[idx] = e;
  endtask

  // Start a run and compare every observable effect against the table model
  task automatic run(input string tag, input int mode, input int sel, input int lat,
                     input bit respond, input int stop_at, input bit disturb);
    int exp_q[$];
    int n, pc, fc, li, exp_cycles, exp_req, cycles, reqs, req_cyc, vi;
    bit ok, last_pass, prev_req, seen_done;
    logic [W-1:0] res, last_res;

    if (mode == 1)      for (int i = 0; i < int'(D); i++) exp_q.push_back(i);
    else if (mode == 2) for (int k = 0; k <= stop_at; k++) exp_q.push_back(k % int'(D));
    else                exp_q.push_back(sel);
    pc = 0; fc = 0; li = 0; last_pass = 0; last_res = '0;
    foreach (exp_q[k]) begin
      vi  = exp_q[k];
      res = respond ? alu(m_op[vi], m_a[vi], m_b[vi]) : '0;
      ok  = respond && (res == m_exp[vi]);
      if (ok) pc++; else fc++;
      last_pass = ok; last_res = res; li = vi;
    end
    n          = exp_q.size();
    exp_cycles = n * (respond ? 3 + lat : 2 + int'(TO));
    exp_req    = n * (respond ? 2 + lat : 1 + int'(TO));

    resp_en = respond; resp_lat = lat;
    mode_i = 2'(mode); sel_i = IDX_W'(sel); start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk({tag, "/busy_go"}, 64'(busy_o), 64'd1);

    cycles = 0; reqs = 0; req_cyc = 0; prev_req = 0; seen_done = 0;
    while (!seen_done && cycles < exp_cycles + 20) begin
      if (dut_req_o) begin
        req_cyc++;
        if (!prev_req) begin
          if (reqs < n) begin
            chk({tag, "/op"}, 64'(dut_op_o), 64'(m_op[exp_q[reqs]]));
            chk({tag, "/a"},  64'(dut_a_o),  64'(m_a[exp_q[reqs]]));
            chk({tag, "/b"},  64'(dut_b_o),  64'(m_b[exp_q[reqs]]));
          end
          reqs++;
          if (mode == 2 && reqs == stop_at + 1) stop_i = 1'b1;
        end
      end
      prev_req = dut_req_o;
      if (disturb && cycles == 1) begin
        start_i = 1'b1; mode_i = 2'd1; sel_i = IDX_W'(sel + 1);
        tbl_we_i = 1'b1; tbl_addr_i = IDX_W'(sel);
        tbl_op_i = OP_W'($urandom); tbl_a_i = W'($urandom);
        tbl_b_i = W'($urandom); tbl_exp_i = W'($urandom);
      end
      if (disturb && cycles == 2) begin
        start_i = 1'b0; tbl_we_i = 1'b0;
      end
      tick();
      cycles++;
      seen_done = done_o;
    end
    chk({tag, "/done_seen"}, 64'(seen_done), 64'd1);
    chk({tag, "/latency"},   64'(cycles), 64'(exp_cycles));
    chk({tag, "/reqs"},      64'(reqs), 64'(n));
    chk({tag, "/req_cycles"},64'(req_cyc), 64'(exp_req));
    chk({tag, "/busy_end"},  64'(busy_o), 64'd0);
    chk({tag, "/pass"},      64'(pass_o), 64'(last_pass));
    chk({tag, "/last_idx"},  64'(last_idx_o), 64'(li));
    chk({tag, "/last_res"},  64'(last_result_o), 64'(last_res));
    chk({tag, "/timeout"},   64'(timeout_o), 64'(!respond));
    chk({tag, "/pass_cnt"},  64'(pass_cnt_o), 64'(pc));
    chk({tag, "/fail_cnt"},  64'(fail_cnt_o), 64'(fc));
    stop_i = 1'b0;
    tick();
    chk({tag, "/done_pulse"}, 64'(done_o), 64'd0);
    chk({tag, "/req_idle"},   64'(dut_req_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(D); i++) begin
      m_op[i] = '0; m_a[i] = '0; m_b[i] = '0; m_exp[i] = '0;
    end
    tick(); tick();
    rst_i = 1'b0;
    tick();
    chk("reset/req",      64'(dut_req_o), 64'd0);
    chk("reset/busy",     64'(busy_o), 64'd0);
    chk("reset/done",     64'(done_o), 64'd0);
    chk("reset/pass",     64'(pass_o), 64'd0);
    chk("reset/timeout",  64'(timeout_o), 64'd0);
    chk("reset/pass_cnt", 64'(pass_cnt_o), 64'd0);
    chk("reset/fail_cnt", 64'(fail_cnt_o), 64'd0);
    chk("reset/last_res", 64'(last_result_o), 64'd0);

    // Table: entry 0 is 15+25=40; entry 3 carries a wrong expected value
    wr(0, OP_W'(0), W'(15), W'(25), W'(40));
    for (int i = 1; i < int'(D); i++) begin
      logic [OP_W-1:0] op;
      logic [W-1:0] a, b, e;
      op = OP_W'($urandom_range(0, 3));
      a  = W'($urandom); b = W'($urandom);
      e  = alu(op, a, b);
      if (i == 3) e = e + W'(1);
      wr(i, op, a, b, e);
    end

    run("single0", 0, 0, 0, 1'b1, -1, 1'b0);
    chk("single0/result40", 64'(last_result_o), 64'd40);
    run("runall", 1, 0, 0, 1'b1, -1, 1'b0);
    for (int t = 0; t < 4; t++)
      run("single_rand", ($urandom_range(0, 1) != 0) ? 3 : 0, int'($urandom_range(0, D - 1)),
          int'($urandom_range(0, 4)), 1'b1, -1, 1'b0);
    run("runall_lat", 1, 0, int'($urandom_range(1, 3)), 1'b1, -1, 1'b0);
    run("timeout", 0, 1, 0, 1'b0, -1, 1'b0);
    run("loop", 2, 0, int'($urandom_range(0, 2)), 1'b1, 10, 1'b0);
    run("busy_ignore", 0, 4, 3, 1'b1, -1, 1'b1);
    run("busy_readback", 3, 4, 0, 1'b1, -1, 1'b0);

    // Synchronous reset while waiting on the DUT
    resp_en = 1'b1; resp_lat = 10;
    mode_i = 2'd0; sel_i = IDX_W'(2); start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick();
    chk("rst_wait/req_before", 64'(dut_req_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_wait/req",      64'(dut_req_o), 64'd0);
    chk("rst_wait/busy",     64'(busy_o), 64'd0);
    chk("rst_wait/pass",     64'(pass_o), 64'd0);
    chk("rst_wait/last_idx", 64'(last_idx_o), 64'd0);
    chk("rst_wait/pass_cnt", 64'(pass_cnt_o), 64'd0);
    chk("rst_wait/fail_cnt", 64'(fail_cnt_o), 64'd0);
    tick();
    for (int i = 0; i < int'(D); i++) begin
      m_op[i] = '0; m_a[i] = '0; m_b[i] = '0; m_exp[i] = '0;
    end
    run("after_rst_zero_tbl", 0, 5, 0, 1'b1, -1, 1'b0);
    wr(6, OP_W'(1), W'(100), W'(58), W'(42));
    run("after_rst", 0, 6, 1, 1'b1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
